// File: rtl/vx_raster_tile_fetch_pkg.sv
// Shared types and constants for the raster tile fetcher.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package vx_raster_tile_fetch_pkg;

    localparam int          RASTER_DCR_DATA_BITS = 32;
    localparam int          TILE_LOGSIZE_DEFAULT = 5;
    // Each tile-buffer entry is two 32-bit words: position, then primitive ID.
    localparam logic [31:0] TILE_ENTRY_BYTES     = 32'd8;
    localparam logic [31:0] TILE_WORD1_OFS       = 32'd4;

    typedef struct packed {
        logic [RASTER_DCR_DATA_BITS-1:0] tbuf_addr;
        logic [RASTER_DCR_DATA_BITS-1:0] tile_count;
        logic [RASTER_DCR_DATA_BITS-1:0] pbuf_addr;
        logic [RASTER_DCR_DATA_BITS-1:0] pbuf_stride;
    } raster_dcrs_t;

    // In-memory tile entry; the low 32 bits are word0.
    typedef struct packed {
        logic [31:0] pid;
        logic [15:0] tile_y;
        logic [15:0] tile_x;
    } raster_tile_t;

    typedef logic [2:0] tile_state_t;

    localparam tile_state_t ST_IDLE  = 3'd0;
    localparam tile_state_t ST_REQ0  = 3'd1;
    localparam tile_state_t ST_WAIT0 = 3'd2;
    localparam tile_state_t ST_REQ1  = 3'd3;
    localparam tile_state_t ST_WAIT1 = 3'd4;
    localparam tile_state_t ST_OUT   = 3'd5;
    localparam tile_state_t ST_DONE  = 3'd6;

endpackage

// File: rtl/vx_raster_tile_fetch_prim_addr.sv
// Primitive record address: pbuf_addr + pid * pbuf_stride, modulo 2^32.
// Latency: combinational; the parent registers the result.
// Backpressure: none, pure datapath.
module vx_raster_tile_fetch_prim_addr
    import vx_raster_tile_fetch_pkg::*;
(
    input  logic [RASTER_DCR_DATA_BITS-1:0] base,
    input  logic [31:0]                     pid,
    input  logic [RASTER_DCR_DATA_BITS-1:0] stride,
    output logic [31:0]                     prim_addr
);

    // Low 32 bits of the product are all that matter for a wrapping address.
    always_comb begin
        prim_addr = base + pid * stride;
    end

endmodule

// File: rtl/vx_raster_tile_fetch.sv
// Walks a tile buffer, fetching each 8-byte entry and emitting tile position plus primitive address.
// Latency: first request 1 cycle after start; 5 cycles per tile with zero-wait memory and sink.
// Backpressure: one request outstanding; request and output hold stable until their ready.
module vx_raster_tile_fetch
    import vx_raster_tile_fetch_pkg::*;
#(
    parameter int TILE_LOGSIZE = TILE_LOGSIZE_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    input  raster_dcrs_t dcrs,
    input  logic         start,
    output logic         busy,
    output logic         done,
    output logic         mem_req_valid,
    input  logic         mem_req_ready,
    output logic [31:0]  mem_req_addr,
    input  logic         mem_rsp_valid,
    output logic         mem_rsp_ready,
    input  logic [31:0]  mem_rsp_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [15:0]  out_pos_x,
    output logic [15:0]  out_pos_y,
    output logic [31:0]  out_pid,
    output logic [31:0]  out_prim_addr
);

    tile_state_t  state;
    raster_dcrs_t dcrs_q;
    logic [31:0]  tile_idx;
    logic [31:0]  tile_idx_next;
    logic [15:0]  tile_x_q;
    logic [15:0]  tile_y_q;
    logic [31:0]  entry_addr;
    logic [31:0]  prim_addr_next;
    raster_tile_t entry;

    // Full entry as seen in WAIT1: word0 already captured, pid arriving on the bus.
    always_comb begin
        entry        = '0;
        entry.tile_x = tile_x_q;
        entry.tile_y = tile_y_q;
        entry.pid    = mem_rsp_data;
    end

    vx_raster_tile_fetch_prim_addr u_prim_addr (
        .base      (dcrs_q.pbuf_addr),
        .pid       (entry.pid),
        .stride    (dcrs_q.pbuf_stride),
        .prim_addr (prim_addr_next)
    );

    // Request address and handshake/status outputs decoded from the state alone.
    always_comb begin
        tile_idx_next = tile_idx + 32'd1;
        entry_addr    = dcrs_q.tbuf_addr + tile_idx * TILE_ENTRY_BYTES;
        mem_req_addr  = (state == ST_REQ1) ? entry_addr + TILE_WORD1_OFS : entry_addr;
        mem_req_valid = (state == ST_REQ0) || (state == ST_REQ1);
        // IDLE and DONE accept and discard stale responses left over from an aborted walk.
        mem_rsp_ready = (state == ST_WAIT0) || (state == ST_WAIT1) ||
                        (state == ST_IDLE)  || (state == ST_DONE);
        out_valid     = (state == ST_OUT);
        busy          = (state != ST_IDLE);
        done          = (state == ST_DONE);
    end

    // Walk sequencer: latch DCRs at launch, fetch both words, hold the output until taken.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            dcrs_q        <= '0;
            tile_idx      <= '0;
            tile_x_q      <= '0;
            tile_y_q      <= '0;
            out_pos_x     <= '0;
            out_pos_y     <= '0;
            out_pid       <= '0;
            out_prim_addr <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        dcrs_q   <= dcrs;
                        tile_idx <= '0;
                        state    <= (dcrs.tile_count == 32'd0) ? ST_DONE : ST_REQ0;
                    end
                end
                ST_REQ0: begin
                    if (mem_req_ready) state <= ST_WAIT0;
                end
                ST_WAIT0: begin
                    if (mem_rsp_valid) begin
                        tile_x_q <= mem_rsp_data[15:0];
                        tile_y_q <= mem_rsp_data[31:16];
                        state    <= ST_REQ1;
                    end
                end
                ST_REQ1: begin
                    if (mem_req_ready) state <= ST_WAIT1;
                end
                ST_WAIT1: begin
                    if (mem_rsp_valid) begin
                        out_pos_x     <= entry.tile_x << TILE_LOGSIZE;
                        out_pos_y     <= entry.tile_y << TILE_LOGSIZE;
                        out_pid       <= entry.pid;
                        out_prim_addr <= prim_addr_next;
                        state         <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        if (tile_idx_next == dcrs_q.tile_count) begin
                            state <= ST_DONE;
                        end else begin
                            tile_idx <= tile_idx_next;
                            state    <= ST_REQ0;
                        end
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vx_raster_tile_fetch.sv
// Scoreboard bench for the raster tile fetcher with a one-outstanding memory model.
// Latency: checks 5-cycle-per-tile timing under zero-wait memory and sink.
// Backpressure: random ready/valid stalls on memory and output channels.
module tb_vx_raster_tile_fetch;
    import vx_raster_tile_fetch_pkg::*;

    localparam int LOG = 5;

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic [31:0] pid;
        logic [31:0] prim;
    } exp_out_t;

    logic         clk = 1'b0;
    logic         reset;
    raster_dcrs_t dcrs;
    logic         start;
    logic         busy, done;
    logic         mem_req_valid, mem_req_ready;
    logic [31:0]  mem_req_addr;
    logic         mem_rsp_valid, mem_rsp_ready;
    logic [31:0]  mem_rsp_data;
    logic         out_valid, out_ready;
    logic [15:0]  out_pos_x, out_pos_y;
    logic [31:0]  out_pid, out_prim_addr;

    logic [31:0]  mem [logic [31:0]];
    logic [31:0]  exp_req [$];
    exp_out_t     exp_out [$];
    logic [31:0]  pending [$];

    int checks   = 0;
    int failures = 0;
    int req_seen = 0;
    bit rnd_mode   = 1'b0;
    bit hold_word1 = 1'b0;

    always #5 clk = ~clk;

    vx_raster_tile_fetch #(.TILE_LOGSIZE(LOG)) dut (
        .clk           (clk),
        .reset         (reset),
        .dcrs          (dcrs),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_ready (mem_rsp_ready),
        .mem_rsp_data  (mem_rsp_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_pos_x     (out_pos_x),
        .out_pos_y     (out_pos_y),
        .out_pid       (out_pid),
        .out_prim_addr (out_prim_addr)
    );

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    task automatic put_entry(input logic [31:0] a, input logic [31:0] w0, input logic [31:0] pid);
        mem[a]         = w0;
        mem[a + 32'd4] = pid;
    endtask

    // Reference model: expected requests and outputs for a walk.
    task automatic push_expect(input logic [31:0] tb, input logic [31:0] cnt,
                               input logic [31:0] pb, input logic [31:0] st);
        for (int i = 0; i < int'(cnt); i++) begin
            logic [31:0] a, w0, pid;
            logic [31:0] sx, sy;
            logic [63:0] full;
            exp_out_t    e;
            a    = tb + 32'(i) * 32'd8;
            w0   = rd(a);
            pid  = rd(a + 32'd4);
            sx   = {16'h0, w0[15:0]} << LOG;
            sy   = {16'h0, w0[31:16]} << LOG;
            full = {32'h0, pb} + {32'h0, pid} * {32'h0, st};
            e.x    = sx[15:0];
            e.y    = sy[15:0];
            e.pid  = pid;
            e.prim = full[31:0];
            exp_req.push_back(a);
            exp_req.push_back(a + 32'd4);
            exp_out.push_back(e);
        end
    endtask

    // Memory and sink model: drives readies/responses at negedge and scoreboards handshakes.
    initial begin
        logic [31:0] last_addr, head;
        exp_out_t    last_out, cur_out;
        bit          req_stall, out_stall;
        req_stall = 1'b0;
        out_stall = 1'b0;
        last_addr = '0;
        last_out  = '0;
        mem_req_ready = 1'b0;
        out_ready     = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            mem_req_ready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
            out_ready     = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
            mem_rsp_valid = 1'b0;
            mem_rsp_data  = 32'hDEAD_BEEF;
            if (pending.size() > 0) begin
                head = pending[0];
                if (!(hold_word1 && head[2]) && (!rnd_mode || $urandom_range(0, 1) == 1)) begin
                    mem_rsp_valid = 1'b1;
                    mem_rsp_data  = rd(head);
                end
            end
            cur_out = {out_pos_x, out_pos_y, out_pid, out_prim_addr};
            if (req_stall && !reset)
                check_val("req_stable", {mem_req_valid, mem_req_addr}, {1'b1, last_addr});
            if (out_stall && !reset)
                check_val("out_stable", {out_valid, cur_out}, {1'b1, last_out});
            if (!reset && mem_req_valid && mem_req_ready) begin
                req_seen++;
                if (exp_req.size() == 0) check_val("req_extra", mem_req_valid, 1'b0);
                else                     check_val("req_addr", mem_req_addr, exp_req.pop_front());
                pending.push_back(mem_req_addr);
            end
            if (mem_rsp_valid && mem_rsp_ready) void'(pending.pop_front());
            if (!reset && out_valid && out_ready) begin
                if (exp_out.size() == 0) check_val("out_extra", out_valid, 1'b0);
                else                     check_val("out_tile", cur_out, exp_out.pop_front());
            end
            req_stall = mem_req_valid && !mem_req_ready && !reset;
            out_stall = out_valid && !out_ready && !reset;
            last_addr = mem_req_addr;
            last_out  = cur_out;
        end
    end

    task automatic run_walk(input logic [31:0] tb, input logic [31:0] cnt, input logic [31:0] pb,
                            input logic [31:0] st, input bit rnd, input bit disturb);
        int cyc;
        bit seen;
        rnd_mode         = rnd;
        dcrs.tbuf_addr   = tb;
        dcrs.tile_count  = cnt;
        dcrs.pbuf_addr   = pb;
        dcrs.pbuf_stride = st;
        push_expect(tb, cnt, pb, st);
        @(negedge clk);
        start = 1'b1;
        cyc   = 0;
        seen  = 1'b0;
        while (!seen && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                check_val("walk_busy", busy, 1'b1);
                if (cnt != 0) check_val("first_req", mem_req_valid, 1'b1);
                else          check_val("empty_done", {done, mem_req_valid}, 2'b10);
            end
            if (done) begin
                seen  = 1'b1;
                start = 1'b0;
            end else if (disturb && (cyc % 3 == 0)) begin
                start            = 1'b1;
                dcrs.tbuf_addr   = $urandom;
                dcrs.tile_count  = $urandom_range(0, 7);
                dcrs.pbuf_addr   = $urandom;
                dcrs.pbuf_stride = $urandom;
            end else begin
                start = 1'b0;
            end
        end
        check_val("walk_done", seen, 1'b1);
        if (!rnd) check_val("walk_cycles", cyc, 1 + 5 * int'(cnt));
        check_val("walk_drained", {exp_req.size(), exp_out.size()}, 64'h0);
        @(negedge clk);
        check_val("after_done", {done, busy}, 2'b00);
        rnd_mode = 1'b0;
    endtask

    initial begin
        int base, cyc;
        reset = 1'b1;
        start = 1'b0;
        dcrs  = '0;
        put_entry(32'h0000_1000, 32'h0003_0002, 32'd7);
        put_entry(32'h0000_1008, 32'h0001_0004, 32'd2);
        put_entry(32'hFFFF_FFF8, 32'h0005_0001, 32'd1);
        put_entry(32'h0000_0000, 32'h0020_0800, 32'd3);

        repeat (3) @(negedge clk);
        check_val("rst_status", {busy, done, mem_req_valid, out_valid}, 4'b0000);
        check_val("rst_outputs", {out_pos_x, out_pos_y, out_pid, out_prim_addr}, 96'h0);
        reset = 1'b0;
        @(negedge clk);

        // Empty walk, basic walk, stalled walk, wrapping addresses, disturbed walk.
        run_walk(32'h0000_1000, 32'd0, 32'h0000_8000, 32'd64, 1'b0, 1'b0);
        run_walk(32'h0000_1000, 32'd2, 32'h0000_8000, 32'd64, 1'b0, 1'b0);
        run_walk(32'h0000_1000, 32'd2, 32'h0000_8000, 32'd64, 1'b1, 1'b0);
        run_walk(32'hFFFF_FFF8, 32'd2, 32'hFFFF_FFF0, 32'h20, 1'b0, 1'b0);
        run_walk(32'h0000_1000, 32'd2, 32'h0000_8000, 32'd64, 1'b1, 1'b1);

        // Abort a walk while the pid response is outstanding.
        hold_word1       = 1'b1;
        dcrs.tbuf_addr   = 32'h0000_1000;
        dcrs.tile_count  = 32'd2;
        dcrs.pbuf_addr   = 32'h0000_8000;
        dcrs.pbuf_stride = 32'd64;
        push_expect(32'h0000_1000, 32'd2, 32'h0000_8000, 32'd64);
        base = req_seen;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 0;
        while (req_seen < base + 2 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check_val("abort_reached", req_seen - base, 2);
        repeat (2) @(negedge clk);
        check_val("wait1_hold", {busy, mem_req_valid, out_valid}, 3'b100);
        check_val("wait1_pending", pending.size(), 1);
        reset = 1'b1;
        @(negedge clk);
        reset      = 1'b0;
        hold_word1 = 1'b0;
        exp_req.delete();
        exp_out.delete();
        check_val("abort_status", {busy, done, mem_req_valid, out_valid}, 4'b0000);
        check_val("abort_outputs", {out_pos_x, out_pos_y, out_pid, out_prim_addr}, 96'h0);
        repeat (3) @(negedge clk);
        check_val("stale_drained", pending.size(), 0);
        check_val("abort_quiet", {busy, mem_req_valid}, 2'b00);

        run_walk(32'h0000_1000, 32'd2, 32'h0000_8000, 32'd64, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vx_raster_tile_fetch.md
VX_RASTER_TILE_FETCH -- requirements
Module: VX_raster_tile_fetch

Interface
REQ-001 SHALL have parameter TILE_LOGSIZE, default 5, log2 of tile edge in pixels.
REQ-002 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port dcrs  input  raster_dcrs_t (4x RASTER_DCR_DATA_BITS=32)  tbuf_addr, tile_count, pbuf_addr, pbuf_stride.
REQ-005 SHALL have port start  input  1  one-cycle pulse launching a tile-buffer walk.
REQ-006 SHALL have ports busy, done  output  1 each  walk in progress; one-cycle completion pulse.
REQ-007 SHALL have ports mem_req_valid/mem_req_ready  output/input  1; mem_req_addr  output  32  byte address.
REQ-008 SHALL have ports mem_rsp_valid/mem_rsp_ready  input/output  1; mem_rsp_data  input  32.
REQ-009 SHALL have ports out_valid/out_ready  output/input  1; out_pos_x, out_pos_y  output  16; out_pid  output  32; out_prim_addr  output  32.

Function
REQ-010 Tile entry SHALL be 8 bytes at tbuf_addr+8*i: word0 {tile_y[31:16], tile_x[15:0]}, word1 primitive ID.
REQ-011 On start in IDLE SHALL latch all four DCR fields, zero tile index i, enter REQ0; start outside IDLE SHALL be ignored.
REQ-012 start with tile_count==0 SHALL go IDLE->DONE: done pulses next cycle, no memory request issued.
REQ-013 States: IDLE, REQ0, WAIT0, REQ1, WAIT1, OUT, DONE.
REQ-014 REQ0: mem_req_valid=1, addr=tbuf+8*i; leave to WAIT0 on valid&&ready; addr/valid stable until accepted.
REQ-015 WAIT0: mem_rsp_ready=1; on mem_rsp_valid capture word0, enter REQ1.
REQ-016 REQ1/WAIT1 as REQ0/WAIT0 with addr=tbuf+8*i+4, capturing pid, then enter OUT.
REQ-017 OUT: out_valid=1, outputs stable until out_valid&&out_ready; then i+1, enter REQ0, or DONE if i+1==tile_count.
REQ-018 out_pos_x = tile_x<<TILE_LOGSIZE, out_pos_y = tile_y<<TILE_LOGSIZE, truncated to 16 bits.
REQ-019 out_prim_addr = pbuf_addr + pid*pbuf_stride, low 32 bits, modulo-2^32 wrap.
REQ-020 All address arithmetic SHALL be 32-bit modulo; tbuf wrap past 0xFFFFFFFF is not flagged.
REQ-021 Only one memory request SHALL be outstanding; responses are in order, untagged.
REQ-022 mem_rsp_ready SHALL be 1 in IDLE and DONE (drains stale responses, discarded); 0 in REQ0/REQ1/OUT.
REQ-023 DONE: done=1 one cycle, then IDLE; busy=1 in every state except IDLE.
REQ-024 Minimum latency with zero-wait memory/sink: 5 cycles per tile; first mem_req_valid 1 cycle after start.
REQ-025 DCR input changes after start SHALL NOT affect an active walk.

Reset
REQ-026 On reset: state IDLE, i=0, busy=0, done=0, mem_req_valid=0, out_valid=0, captured registers 0.
REQ-027 Reset mid-walk SHALL abort without further requests or outputs; in-flight responses are drained as stale per REQ-022.

Structure
REQ-028 Tile entry layout (tile_x/tile_y/pid fields) as a packed struct raster_tile_t and the state enum in package raster_types alongside raster_dcrs_t.
REQ-029 Entry byte size (8) and TILE_LOGSIZE default as constants in raster_types.
REQ-030 Single module; the 32x32 multiply for out_prim_addr MAY be a sub-module VX_raster_prim_addr (combinational, registered in WAIT1->OUT).

Verification
REQ-031 tile_count=0, start -> done pulse 1 cycle later, zero mem requests, busy high 1 cycle.
REQ-032 tbuf=0x1000, count=2, entries {0x00030002,7},{0x00010004,2}, pbuf=0x8000, stride=64, TILE_LOGSIZE=5 -> requests 0x1000,0x1004,0x1008,0x100C; outputs (64,96,7,0x81C0), (128,32,2,0x8080); done.
REQ-033 mem_req_ready and out_ready toggled randomly -> addr/outputs stable while stalled, same results as REQ-032.
REQ-034 pbuf=0xFFFFFFF0, stride=0x20, pid=1 -> out_prim_addr=0x00000010 (wrap).
REQ-035 start repeated while busy, DCRs changed mid-walk -> ignored, results unchanged.
REQ-036 reset asserted in WAIT1 with response pending -> IDLE, outputs zero, response drained, next start runs cleanly.
